// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready
// requesters; operands are registered toward the ALU and the result is returned tagged.
`timescale 1ns/1ps
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  input  logic [7:0]           req_op,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_ctrl,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero
);

  localparam int unsigned OP_W = 4;
  localparam logic [OP_W-1:0] OP_LAST = OP_W'(9);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_win;
  logic               w_accept;
  logic               w_rsp_done;
  logic [1:0]         w_req_ready;
  logic               r_last_grant;
  logic               r_grant;
  logic [TAG_W-1:0]   r_tag;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [OP_W-1:0]    r_alu_ctrl;
  logic [1:0]         r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_result;
  logic               r_rsp_zero;
  logic               r_rsp_err;
  logic [TAG_W-1:0]   r_rsp_tag;

  assign w_win      = (&req_valid) ? ~r_last_grant : req_valid[1];
  assign w_rsp_done = |(r_rsp_valid & rsp_ready);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and request acceptance
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 2'b00;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((|req_valid) && !reset) begin
          w_req_ready = w_win ? 2'b10 : 2'b01;
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: if (w_rsp_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, result capture and response handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_tag        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctrl   <= '0;
      r_rsp_valid  <= 2'b00;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_tag    <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a      <= w_win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        r_alu_b      <= w_win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
        r_alu_ctrl   <= w_win ? req_op[7:4] : req_op[3:0];
        r_tag        <= w_win ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
        r_grant      <= w_win;
        r_last_grant <= w_win;
      end
      if (r_state == S_EXEC) begin
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
        r_rsp_err    <= (r_alu_ctrl > OP_LAST);
        r_rsp_tag    <= r_tag;
        r_rsp_valid  <= r_grant ? 2'b10 : 2'b01;
      end else if (w_rsp_done) begin
        r_rsp_valid  <= 2'b00;
      end
    end
  end

  assign req_ready  = w_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;
  assign rsp_tag    = r_rsp_tag;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_ctrl   = r_alu_ctrl;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: per-requester drivers push expected
// responses on acceptance; a monitor compares every presented response.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        z;
    logic        e;
  } txn_t;

  typedef struct {
    int   id;
    txn_t t;
    int   acc_cyc;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0]       req_a, req_b;
  logic [7:0]        req_op, req_tag;
  logic [31:0]       rsp_result, alu_a, alu_b, alu_result;
  logic              rsp_zero, rsp_err, alu_zero;
  logic [3:0]        rsp_tag, alu_ctrl;

  logic              vld0, vld1;
  logic [31:0]       a0, a1, b0, b1;
  logic [3:0]        op0, op1, tag0, tag1;

  assign req_valid = {vld1, vld0};
  assign req_a     = {a1, a0};
  assign req_b     = {b1, b0};
  assign req_op    = {op1, op0};
  assign req_tag   = {tag1, tag0};

  alu_share_arbiter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Reference model of the shared combinational ALU
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a << alu_b[4:0];
      4'd5: alu_result = 32'($signed(alu_a) < $signed(alu_b));
      4'd6: alu_result = 32'(alu_a < alu_b);
      4'd7: alu_result = alu_a ^ alu_b;
      4'd8: alu_result = alu_a >> alu_b[4:0];
      4'd9: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  txn_t q0[$];
  txn_t q1[$];
  exp_t sb[$];
  int   glog[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                              input logic [3:0] tag, input logic [31:0] res, input logic z,
                              input logic e);
    txn_t t;
    t.a = a; t.b = b; t.op = op; t.tag = tag; t.res = res; t.z = z; t.e = e;
    return t;
  endfunction

  // Presents queued transactions for one requester and logs acceptances
  task automatic run_drv(input int id);
    txn_t t;
    exp_t x;
    bit   acc;
    forever begin
      @(negedge clk);
      acc = req_valid[id] && req_ready[id] && !reset;
      @(posedge clk);
      #1;
      if (acc) begin
        if (id == 0) begin t = q0.pop_front(); vld0 = 1'b0; end
        else         begin t = q1.pop_front(); vld1 = 1'b0; end
        x.id = id; x.t = t; x.acc_cyc = cyc;
        sb.push_back(x);
        glog.push_back(id);
        chk($sformatf("alu_a_r%0d", id), alu_a, t.a);
        chk($sformatf("alu_b_r%0d", id), alu_b, t.b);
        chk($sformatf("alu_ctrl_r%0d", id), 32'(alu_ctrl), 32'(t.op));
      end
      if (id == 0) begin
        if (!vld0 && q0.size() > 0) begin
          t = q0[0]; a0 = t.a; b0 = t.b; op0 = t.op; tag0 = t.tag; vld0 = 1'b1;
        end
      end else begin
        if (!vld1 && q1.size() > 0) begin
          t = q1[0]; a1 = t.a; b1 = t.b; op1 = t.op; tag1 = t.tag; vld1 = 1'b1;
        end
      end
    end
  endtask

  initial run_drv(0);
  initial run_drv(1);

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (req_ready == 2'b11) begin
          checks++; errors++;
          $display("FAIL req_ready_both: req_ready=%b required one-hot or zero", req_ready);
        end
        if (rsp_valid != 2'b00) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: rsp_valid=%b required 00 (nothing outstanding)", rsp_valid);
          end else begin
            e = sb[0];
            chk("rsp_valid", 32'(rsp_valid), (e.id == 0) ? 32'd1 : 32'd2);
            chk("rsp_result", rsp_result, e.t.res);
            chk("rsp_zero", 32'(rsp_zero), 32'(e.t.z));
            chk("rsp_err", 32'(rsp_err), 32'(e.t.e));
            chk("rsp_tag", 32'(rsp_tag), 32'(e.t.tag));
            if (!mon_seen) chk("latency", 32'(cyc), 32'(e.acc_cyc + 1));
            mon_seen = 1'b1;
            if (rsp_ready[e.id]) begin
              void'(sb.pop_front());
              mon_seen = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || vld0 || vld1 || sb.size() > 0) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL timeout_%s: %0d responses still outstanding after %0d cycles", name, sb.size(), n);
    end
  endtask

  task automatic chk_grants(input string name, input int start, input int n,
                            input int g0, input int g1, input int g2, input int g3);
    int exp_g[4];
    exp_g[0] = g0; exp_g[1] = g1; exp_g[2] = g2; exp_g[3] = g3;
    chk({name, "_count"}, 32'(glog.size() - start), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (start + i < glog.size())
        chk($sformatf("%s_grant%0d", name, i), 32'(glog[start + i]), 32'(exp_g[i]));
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({name, "_rsp_result"}, rsp_result, 32'd0);
    chk({name, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
    chk({name, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({name, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
    chk({name, "_alu_a"}, alu_a, 32'd0);
    chk({name, "_alu_b"}, alu_b, 32'd0);
    chk({name, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
  endtask

  initial begin
    int gs;
    int n;
    reset = 1'b1; rsp_ready = 2'b11;
    vld0 = 1'b0; vld1 = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; op0 = '0; op1 = '0; tag0 = '0; tag1 = '0;

    // Tie from reset, then both held valid: grants 0,1,0,1
    q0.push_back(mk(32'd1, 32'd1, 4'd0, 4'd1, 32'd2, 1'b0, 1'b0));
    q0.push_back(mk(32'd10, 32'd20, 4'd0, 4'd3, 32'd30, 1'b0, 1'b0));
    q1.push_back(mk(32'hF, 32'hF, 4'd7, 4'd2, 32'd0, 1'b1, 1'b0));
    q1.push_back(mk(32'hF0, 32'h0F, 4'd2, 4'd4, 32'd0, 1'b1, 1'b0));
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outs("reset");
    gs = glog.size();
    reset = 1'b0;
    wait_idle("rr");
    chk_grants("rr", gs, 4, 0, 1, 0, 1);

    // Single SUB from requester 0
    q0.push_back(mk(32'd5, 32'd3, 4'd1, 4'd7, 32'd2, 1'b0, 1'b0));
    wait_idle("single");

    // Backpressure on requester 1 with requester 0 pending
    rsp_ready = 2'b01;
    gs = glog.size();
    q1.push_back(mk(32'h8000_0000, 32'd4, 4'd9, 4'd5, 32'hF800_0000, 1'b0, 1'b0));
    n = 0;
    while (!rsp_valid[1] && n < 20) begin @(posedge clk); #2; n++; end
    chk("bp_rsp_arrived", 32'(rsp_valid[1]), 32'd1);
    q0.push_back(mk(32'h0F00, 32'h00F0, 4'd3, 4'd6, 32'h0FF0, 1'b0, 1'b0));
    repeat (5) begin
      @(posedge clk); #2;
      chk("bp_r0_held_off", 32'(req_ready[0]), 32'd0);
      chk("bp_rsp_valid_held", 32'(rsp_valid), 32'd2);
    end
    rsp_ready = 2'b11;
    wait_idle("bp");
    chk_grants("bp", gs, 2, 1, 0, 0, 0);

    // Unsupported op followed by SLT
    q0.push_back(mk(32'd3, 32'd4, 4'd12, 4'd8, 32'd0, 1'b1, 1'b1));
    q0.push_back(mk(32'hFFFF_FFFF, 32'd0, 4'd5, 4'd9, 32'd1, 1'b0, 1'b0));
    wait_idle("unsup");

    // Unsigned compare and shifts
    q1.push_back(mk(32'hFFFF_FFFF, 32'd0, 4'd6, 4'hA, 32'd0, 1'b1, 1'b0));
    q0.push_back(mk(32'd1, 32'd31, 4'd4, 4'hB, 32'h8000_0000, 1'b0, 1'b0));
    q1.push_back(mk(32'h8000_0000, 32'd31, 4'd8, 4'hC, 32'd1, 1'b0, 1'b0));
    wait_idle("shift");

    // Reset during EXEC abandons the transaction
    gs = glog.size();
    q0.push_back(mk(32'd2, 32'd3, 4'd0, 4'hD, 32'd5, 1'b0, 1'b0));
    n = 0;
    while (glog.size() == gs && n < 20) begin @(posedge clk); #2; n++; end
    chk("midreset_accepted", 32'(glog.size() - gs), 32'd1);
    reset = 1'b1;
    @(posedge clk); #2;
    sb.delete();
    mon_seen = 1'b0;
    chk_reset_outs("midreset");
    q0.push_back(mk(32'd4, 32'd4, 4'd0, 4'hE, 32'd8, 1'b0, 1'b0));
    q1.push_back(mk(32'd9, 32'd9, 4'd1, 4'hF, 32'd0, 1'b1, 1'b0));
    @(posedge clk); #2;
    gs = glog.size();
    reset = 1'b0;
    wait_idle("postreset");
    chk_grants("postreset", gs, 2, 0, 1, 0, 0);
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
